// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-requester memory access controller.
// The protected-window check lives here so any block can reuse it.
package mem_ctrl_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int KEY_W  = 16;

  localparam logic [ADDR_W-1:0] DEF_PROT_BASE = 10'h300;
  localparam logic [ADDR_W-1:0] DEF_PROT_TOP  = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Zero-extended compare keeps the window test meaningful when TOP is the last address.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] top);
    logic [ADDR_W:0] a_ext;
    a_ext = {1'b0, addr};
    return (a_ext >= {1'b0, base}) && (a_ext <= {1'b0, top});
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-grant pointer
// updated only when the grant is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    last_d   = last_q;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      grant_id = ~last_q;
    end else if (req[1]) begin
      grant_id = 1'b1;
    end
    if (req != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
    if (accept && (req != 2'b00)) begin
      last_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates two requesters onto the memory primary port with a fixed
// accept/issue/response sequence and key-gated protected address window.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PROT_BASE = DEF_PROT_BASE,
  parameter logic [ADDR_W-1:0] PROT_TOP  = DEF_PROT_TOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [KEY_W-1:0]  r0_key,
  output logic              r0_ready,
  output logic              r0_done,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [KEY_W-1:0]  r1_key,
  output logic              r1_ready,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_wenable,
  output logic              mem_renable,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic [KEY_W-1:0]  mem_key_access,
  output logic [7:0]        viol_count
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gid_q, gid_d;
  logic              viol_q, viol_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [1:0]        grant;
  logic              grant_id;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [KEY_W-1:0]  sel_key;
  logic              resp_ok_read;

  assign accept = rst_n && (state_q == ST_IDLE) && (r0_req || r1_req);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({r1_req, r0_req}),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_addr = grant_id ? r1_addr : r0_addr;
  assign sel_key  = grant_id ? r1_key  : r0_key;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    viol_d  = viol_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          we_d    = grant_id ? r1_we    : r0_we;
          wdata_d = grant_id ? r1_wdata : r0_wdata;
          addr_d  = sel_addr;
          gid_d   = grant_id;
          viol_d  = in_window(sel_addr, PROT_BASE, PROT_TOP) && (sel_key != mem_key_access);
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        if (viol_q && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gid_q   <= 1'b0;
      viol_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
      viol_q  <= viol_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are the only qualifiers; address and data lines always show the latched values.
  assign mem_wenable       = (state_q == ST_ISSUE) && !viol_q && we_q;
  assign mem_renable       = (state_q == ST_ISSUE) && !viol_q && !we_q;
  assign mem_write_address = addr_q;
  assign mem_read_address  = addr_q;
  assign mem_data_in       = wdata_q;
  assign viol_count        = cnt_q;

  assign r0_ready = accept && grant[0];
  assign r1_ready = accept && grant[1];

  assign r0_done  = (state_q == ST_RESP) && !gid_q;
  assign r1_done  = (state_q == ST_RESP) && gid_q;
  assign r0_err   = r0_done && viol_q;
  assign r1_err   = r1_done && viol_q;

  assign resp_ok_read = !we_q && !viol_q;
  assign r0_rdata = (r0_done && resp_ok_read) ? mem_data_out : '0;
  assign r1_rdata = (r1_done && resp_ok_read) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against a word-array
// reference model, with a behavioural registered-read memory attached.
module tb_mem_access_ctrl;

  localparam int WIN_LO = 'h300;
  localparam int WIN_HI = 'h3FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [9:0]  addr_v [2];
  logic [31:0] wdata_v [2];
  logic [15:0] key_v [2];

  logic        r0_ready, r0_done, r0_err, r1_ready, r1_done, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_wenable, mem_renable;
  logic [9:0]  mem_write_address, mem_read_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic [15:0] mem_key_access;
  logic [7:0]  viol_count;

  logic [1:0]  ready_v, done_v, err_v;
  assign ready_v = {r1_ready, r0_ready};
  assign done_v  = {r1_done, r0_done};
  assign err_v   = {r1_err, r0_err};

  logic [31:0] env_mem [1024];
  logic [31:0] ref_mem [1024];
  int          ref_count;
  int          ref_last;
  int          tests_run;
  int          tests_failed;

  mem_access_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .r0_req            (req_v[0]),
    .r0_we             (we_v[0]),
    .r0_addr           (addr_v[0]),
    .r0_wdata          (wdata_v[0]),
    .r0_key            (key_v[0]),
    .r0_ready          (r0_ready),
    .r0_done           (r0_done),
    .r0_err            (r0_err),
    .r0_rdata          (r0_rdata),
    .r1_req            (req_v[1]),
    .r1_we             (we_v[1]),
    .r1_addr           (addr_v[1]),
    .r1_wdata          (wdata_v[1]),
    .r1_key            (key_v[1]),
    .r1_ready          (r1_ready),
    .r1_done           (r1_done),
    .r1_err            (r1_err),
    .r1_rdata          (r1_rdata),
    .mem_wenable       (mem_wenable),
    .mem_renable       (mem_renable),
    .mem_write_address (mem_write_address),
    .mem_read_address  (mem_read_address),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out),
    .mem_key_access    (mem_key_access),
    .viol_count        (viol_count)
  );

  always #5 clk = ~clk;

  // Word memory with registered read data, as seen on the primary port.
  always @(posedge clk) begin
    if (mem_wenable) env_mem[mem_write_address] <= mem_data_in;
    if (mem_renable) mem_data_out <= env_mem[mem_read_address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One complete transaction from a single requester, checked cycle by cycle.
  task automatic applyStimulus(input int id, input logic we, input logic [9:0] addr,
                               input logic [31:0] wdata, input logic [15:0] key);
    logic        exp_viol;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_done;
    int          w;
    exp_viol  = (int'(addr) >= WIN_LO) && (int'(addr) <= WIN_HI) && (key != mem_key_access);
    exp_rdata = (we || exp_viol) ? 32'h0 : ref_mem[addr];
    exp_done  = 2'b00;
    exp_done[id] = 1'b1;
    req_v[id] = 1'b1; we_v[id] = we; addr_v[id] = addr; wdata_v[id] = wdata; key_v[id] = key;
    w = 0;
    #1;
    while (!ready_v[id] && w < 8) begin
      @(negedge clk); #1; w++;
    end
    checkOutput("ready", 32'(ready_v[id]), 32'd1);
    if (!ready_v[id]) begin
      req_v[id] = 1'b0;
      @(negedge clk);
      return;
    end
    checkOutput("ready_other", 32'(ready_v[1-id]), 32'd0);
    ref_last = id;
    @(negedge clk);
    req_v[id] = 1'b0; addr_v[id] = 10'($urandom); wdata_v[id] = $urandom; key_v[id] = 16'($urandom);
    we_v[id] = 1'($urandom);
    #1;
    checkOutput("issue_wen", 32'(mem_wenable), 32'(we && !exp_viol));
    checkOutput("issue_ren", 32'(mem_renable), 32'(!we && !exp_viol));
    checkOutput("issue_addr", 32'(mem_read_address), 32'(addr));
    checkOutput("issue_waddr", 32'(mem_write_address), 32'(addr));
    checkOutput("issue_wdata", mem_data_in, wdata);
    checkOutput("issue_nodone", 32'(done_v), 32'd0);
    @(negedge clk); #1;
    if (exp_viol) begin
      if (ref_count < 255) ref_count++;
    end else if (we) begin
      ref_mem[addr] = wdata;
    end
    checkOutput("resp_done", 32'(done_v), 32'(exp_done));
    checkOutput("resp_err", 32'(err_v), exp_viol ? 32'(exp_done) : 32'd0);
    checkOutput("resp_rdata", (id == 1) ? r1_rdata : r0_rdata, exp_rdata);
    checkOutput("resp_other_rdata", (id == 1) ? r0_rdata : r1_rdata, 32'h0);
    checkOutput("viol_count", 32'(viol_count), 32'(ref_count));
    @(negedge clk);
  endtask

  int          ngr, pend_c, pend_id, last_c, gid;
  logic        pend_valid;
  logic [1:0]  exp_done2;
  logic [9:0]  rnd_addr;
  logic [15:0] rnd_key;

  initial begin
    tests_run = 0; tests_failed = 0;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    mem_data_out = 32'h0;
    mem_key_access = 16'h0032;
    req_v = 2'b00; we_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_v[i] = 10'h0; wdata_v[i] = 32'h0; key_v[i] = 16'h0;
    end
    ref_count = 0; ref_last = 1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ready", 32'(ready_v), 32'd0);
    checkOutput("rst_done", 32'(done_v), 32'd0);
    checkOutput("rst_err", 32'(err_v), 32'd0);
    checkOutput("rst_strobes", 32'({mem_wenable, mem_renable}), 32'd0);
    checkOutput("rst_rdata", r0_rdata | r1_rdata, 32'h0);
    checkOutput("rst_addr", 32'({mem_write_address, mem_read_address}), 32'd0);
    checkOutput("rst_wdata", mem_data_in, 32'h0);
    checkOutput("rst_count", 32'(viol_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain write then read back through the same requester.
    applyStimulus(0, 1'b1, 10'h010, 32'hDEADBEEF, 16'h0000);
    applyStimulus(0, 1'b0, 10'h010, 32'h0, 16'h0000);

    // Blocked write into the window, then an authorised read of the same word.
    applyStimulus(1, 1'b1, 10'h300, 32'h12345678, 16'h0031);
    checkOutput("first_viol", 32'(viol_count), 32'd1);
    applyStimulus(1, 1'b0, 10'h300, 32'h0, 16'h0032);

    // Both requesters hold read requests through four grants.
    req_v = 2'b11; we_v = 2'b00;
    addr_v[0] = 10'h020; addr_v[1] = 10'h0A5;
    key_v[0] = 16'h0; key_v[1] = 16'h0;
    ngr = 0; pend_valid = 1'b0; pend_c = 0; pend_id = 0; last_c = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp_done2 = 2'b00;
      if (pend_valid && c == pend_c + 2) exp_done2[pend_id] = 1'b1;
      checkOutput("arb_done", 32'(done_v), 32'(exp_done2));
      if (exp_done2 != 2'b00)
        checkOutput("arb_rdata", (pend_id == 1) ? r1_rdata : r0_rdata,
                    ref_mem[(pend_id == 1) ? 10'h0A5 : 10'h020]);
      if (ready_v != 2'b00) begin
        gid = r1_ready ? 1 : 0;
        checkOutput("arb_onehot", 32'(r0_ready && r1_ready), 32'd0);
        checkOutput("arb_grant", 32'(gid), 32'(1 - ref_last));
        if (ngr > 0) checkOutput("arb_spacing", 32'(c - last_c), 32'd3);
        ref_last = gid;
        last_c = c; pend_c = c; pend_id = gid; pend_valid = 1'b1;
        ngr++;
      end
      @(negedge clk);
      if (ngr == 4) req_v = 2'b00;
    end
    checkOutput("arb_grants", 32'(ngr), 32'd4);

    // Wrong key outside the window is ignored.
    applyStimulus(0, 1'b0, 10'h100, 32'h0, 16'hBAD0);

    // Randomized mix, biased toward a small set of addresses in and out of the window.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) mem_key_access = 16'($urandom);
      rnd_addr = {($urandom_range(1) == 1) ? 2'b11 : 2'b00, 4'b0000, 4'($urandom)};
      rnd_key  = ($urandom_range(1) == 1) ? mem_key_access : 16'($urandom);
      applyStimulus(int'($urandom_range(1)), 1'($urandom), rnd_addr, $urandom, rnd_key);
    end

    // Enough blocked writes to push the violation counter into saturation.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(i % 2, 1'b1, 10'(WIN_LO + (i % 256)), $urandom, mem_key_access ^ 16'h0001);
    end
    checkOutput("viol_sat", 32'(viol_count), 32'h000000FF);
    applyStimulus(1, 1'b0, 10'h300, 32'h0, mem_key_access);

    // Reset while a read is in the issue cycle: abandoned, no done, pointer restored.
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 10'h020; key_v[0] = 16'h0;
    #1;
    checkOutput("rstmid_ready", 32'(r0_ready), 32'd1);
    @(negedge clk);
    req_v[0] = 1'b0;
    #1;
    checkOutput("rstmid_issue", 32'(mem_renable), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checkOutput("rstmid_strobes", 32'({mem_wenable, mem_renable}), 32'd0);
    checkOutput("rstmid_done", 32'(done_v), 32'd0);
    checkOutput("rstmid_count", 32'(viol_count), 32'd0);
    rst_n = 1'b1;
    ref_count = 0; ref_last = 1;
    @(negedge clk); #1;
    checkOutput("rstmid_nodone", 32'(done_v), 32'd0);
    @(negedge clk);
    req_v = 2'b11; we_v = 2'b00;
    addr_v[0] = 10'h020; addr_v[1] = 10'h0A5;
    #1;
    checkOutput("rstmid_tie", 32'(ready_v), 32'b01);
    @(negedge clk);
    req_v = 2'b00;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Two-requester controller for the core's 1024×32 word memory primary port (write_address/read_address/data_in/data_out). Arbitrates round-robin between the CPU load/store unit (requester 0) and the crypto/DMA engine (requester 1), sequences each access through a fixed three-cycle request/issue/response flow, and gates a protected address window with the memory's 16-bit key_access value. Illegal accesses are blocked before reaching memory and counted.

## Interface
- PROT_BASE, 10'h300, first word address of protected window (inclusive)
- PROT_TOP, 10'h3FF, last word address of protected window (inclusive)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- rN_req  in  1  requester N (N=0,1) has a transaction pending; held until rN_ready
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  10  word address
- rN_wdata  in  32  write data
- rN_key  in  16  access key presented with the transaction
- rN_ready  out  1  transaction accepted this cycle
- rN_done  out  1  one-cycle completion pulse
- rN_err  out  1  valid with rN_done; 1 = key violation, access blocked
- rN_rdata  out  32  read data, valid with rN_done on reads
- mem_wenable, mem_renable  out  1  memory strobes
- mem_write_address, mem_read_address  out  10  memory addresses
- mem_data_in  out  32  memory write data
- mem_data_out  in  32  memory registered read data
- mem_key_access  in  16  reference key from memory block
- viol_count  out  8  saturating count of blocked accesses

## Operation
- FSM: IDLE → ISSUE → RESP → IDLE.
- IDLE: if any rN_req, grant one combinationally, assert its rN_ready for one cycle, latch we/addr/wdata, the grant id, and the violation flag. Next state ISSUE. No request: stay.
- Arbitration: round-robin on last-grant pointer. Both requesting → grant the one not granted last. Single requester always wins. Pointer resets to "r1 last", so r0 wins the first tie.
- Violation: latched addr in [PROT_BASE, PROT_TOP] and rN_key ≠ mem_key_access. Outside window the key is ignored.
- ISSUE: no violation → assert mem_wenable (write) or mem_renable (read) for exactly this cycle; addresses/data from latches. Violation → both strobes 0, viol_count += 1 saturating at 8'hFF.
- RESP: assert granted rN_done; rN_err = latched flag; reads: rN_rdata = mem_data_out, or 32'h0 on violation. Writes: rN_rdata = 32'h0. Return to IDLE.
- ready asserted only in IDLE; requests arriving in ISSUE/RESP wait. The non-granted requester's outputs stay 0.
- Memory address/data outputs drive latched values at all times; only the strobes qualify them.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, all ready/done/err/strobes 0, rdata 0, mem addresses/data 0, viol_count 0, pointer "r1 last". A transaction in flight is abandoned, and no done is produced.
- Accept at cycle T (ready=1) → memory strobe at T+1 → done/err/rdata at T+2. Next accept is possible at T+3, so peak throughput is 1 transaction per 3 cycles.
- Read latency is fixed for both requesters and for blocked accesses alike.
- rN_req dropped before ready: no transaction. Request changes after ready have no effect on the latched transaction.

## Structure
- Shared package mem_ctrl_pkg: state enum (IDLE/ISSUE/RESP), ADDR_W=10, DATA_W=32, KEY_W=16, default PROT_BASE/PROT_TOP.
- One sub-module: rr_arb2 (2-way round-robin grant with pointer update on accept). FSM, latches, key check and counter stay in the top.

## Test plan
- r0 write addr 10'h010 data 32'hDEADBEEF, then r0 read 10'h010 → mem_wenable at T+1, second transaction returns rdata 32'hDEADBEEF, err=0, done at T+2.
- r0 and r1 request reads together, held for 4 grants → grants r0, r1, r0, r1; ready pulses 3 cycles apart.
- r1 write addr 10'h300 key 16'h0031 with mem_key_access 16'h0032 → no mem_wenable, r1_err=1 with done, viol_count=1; a following read of 10'h300 with key 16'h0032 returns the old contents.
- r0 read 10'h100 with wrong key → normal access, err=0 (outside window).
- 300 blocked accesses → viol_count saturates at 8'hFF.
- rst_n low during ISSUE → strobes 0 on the next cycle, no done pulse, viol_count 0, then r0 wins the first tie after release.
